ps2_mouse_host_ctrl: RTL and testbench

Synthesizable PS/2 mouse host-side sequencer. It sits above a byte-level PS/2 transceiver (bit timing, parity and line drive live there).
- Runs the power-up/reset command script: reset, IntelliMouse knock, read ID, enable reporting.
- Handles ACK, resend and timeouts.
- Assembles 3- or 4-byte movement packets into decoded outputs for the Minimig mouse/joystick logic.

---
 rtl/ps2_mouse_host_ctrl_if.sv | 16 +
 rtl/ps2_mouse_host_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_mouse_host_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_host_ctrl_if.sv
// Byte-level link between the PS/2 mouse sequencer (master) and the PS/2 transceiver (slave).
interface ps2_mouse_host_ctrl_if;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;

  modport master (output tx_req, tx_data,
                  input  tx_busy, tx_done, tx_err, rx_valid, rx_data, rx_err);
  modport slave  (input  tx_req, tx_data,
                  output tx_busy, tx_done, tx_err, rx_valid, rx_data, rx_err);
endinterface

// File: rtl/ps2_mouse_host_ctrl.sv
// PS/2 mouse host sequencer: init script, ACK/resend/timeout handling, packet decode.
// Optional PS2_HOTPLUG_EN: AA 00 seen at a packet boundary in stream restarts the script at idx 1.
module ps2_mouse_host_ctrl #(
  parameter int ACK_TIMEOUT = 200000,
  parameter int BAT_TIMEOUT = 4000000,
  parameter int RETRY_MAX   = 3,
  parameter int ERR_BACKOFF = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  ps2_mouse_host_ctrl_if.master  bus,
  output logic                   ready,
  output logic                   init_err,
  output logic                   wheel,
  output logic                   pkt_valid,
  output logic [2:0]             btn,
  output logic [8:0]             dx,
  output logic [8:0]             dy,
  output logic [3:0]             dz,
  output logic [1:0]             ovf
);
  localparam int MAXT_AB = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
  localparam int MAXT    = (MAXT_AB > ERR_BACKOFF) ? MAXT_AB : ERR_BACKOFF;
  localparam int TW      = $clog2(MAXT + 1);
  localparam int RW      = $clog2(RETRY_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, RETRY, ERROR, STREAM
  } state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [RW-1:0] retry;
  logic [TW-1:0] timer;
  logic          bat_seen;
  logic [1:0]    pkt_idx;
  logic [7:0]    b0, b1, b2;

  logic          rx_ok, ack_to, bat_to, err_to;
  logic [1:0]    last_idx;
  logic [7:0]    y_lo;

  assign rx_ok    = bus.rx_valid & ~bus.rx_err;
  assign ack_to   = timer >= TW'(ACK_TIMEOUT - 1);
  assign bat_to   = timer >= TW'(BAT_TIMEOUT - 1);
  assign err_to   = timer >= TW'(ERR_BACKOFF - 1);
  assign last_idx = wheel ? 2'd3 : 2'd2;
  // Y low byte is still on the bus when a 3-byte packet completes
  assign y_lo     = (pkt_idx == 2'd2) ? bus.rx_data : b2;

  function automatic logic [7:0] rom(input logic [3:0] i);
    case (i)
      4'd0:    rom = 8'hFF;
      4'd1:    rom = 8'hF3;
      4'd2:    rom = 8'hC8;
      4'd3:    rom = 8'hF3;
      4'd4:    rom = 8'h64;
      4'd5:    rom = 8'hF3;
      4'd6:    rom = 8'h50;
      4'd7:    rom = 8'hF2;
      default: rom = 8'hF4;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      retry       <= '0;
      timer       <= '0;
      bat_seen    <= 1'b0;
      pkt_idx     <= '0;
      b0          <= '0;
      b1          <= '0;
      b2          <= '0;
      bus.tx_req  <= 1'b0;
      bus.tx_data <= '0;
      ready       <= 1'b0;
      init_err    <= 1'b0;
      wheel       <= 1'b0;
      pkt_valid   <= 1'b0;
      btn         <= '0;
      dx          <= '0;
      dy          <= '0;
      dz          <= '0;
      ovf         <= '0;
    end else begin
      bus.tx_req <= 1'b0;
      pkt_valid  <= 1'b0;
      if (timer != '1) timer <= timer + TW'(1);
      if (rx_ok)       timer <= '0;

      case (state)
        IDLE: begin
          state <= SEND;
          timer <= '0;
        end
        SEND: if (!bus.tx_busy) begin
          bus.tx_req  <= 1'b1;
          bus.tx_data <= rom(idx);
          state       <= WAIT_TX;
          timer       <= '0;
        end
        WAIT_TX: begin
          if (bus.tx_done) begin
            state <= WAIT_ACK;
            timer <= '0;
          end else if (bus.tx_err) begin
            state <= RETRY;
            timer <= '0;
          end
        end
        WAIT_ACK: begin
          if (bus.rx_err || (!bus.rx_valid && ack_to)) begin
            state <= RETRY;
            timer <= '0;
          end else if (bus.rx_valid) begin
            timer <= '0;
            if (bus.rx_data == 8'hFA) begin
              case (idx)
                4'd0: begin state <= WAIT_BAT; bat_seen <= 1'b0; end
                4'd7: state <= WAIT_ID;
                4'd8: begin state <= STREAM; ready <= 1'b1; pkt_idx <= '0; end
                default: begin idx <= idx + 4'd1; retry <= '0; state <= SEND; end
              endcase
            end else if (bus.rx_data == 8'hFE) begin
              state <= RETRY;
            end else begin
              state <= ERROR;
            end
          end
        end
        WAIT_BAT: begin
          if (rx_ok) begin
            if (!bat_seen) begin
              if (bus.rx_data == 8'hAA) bat_seen <= 1'b1;
            end else if (bus.rx_data == 8'h00) begin
              idx   <= 4'd1;
              retry <= '0;
              state <= SEND;
            end else begin
              state <= ERROR;
            end
          end else if (bat_to) begin
            state <= ERROR;
            timer <= '0;
          end
        end
        WAIT_ID: begin
          if (rx_ok) begin
            wheel <= (bus.rx_data == 8'h03);
            idx   <= 4'd8;
            retry <= '0;
            state <= SEND;
          end else if (ack_to) begin
            state <= RETRY;
            timer <= '0;
          end
        end
        RETRY: begin
          retry <= retry + RW'(1);
          timer <= '0;
          state <= (retry + RW'(1) >= RW'(RETRY_MAX)) ? ERROR : SEND;
        end
        ERROR: begin
          if (err_to) begin
            init_err <= 1'b0;
            idx      <= '0;
            retry    <= '0;
            state    <= SEND;
            timer    <= '0;
          end else begin
            init_err <= 1'b1;
            ready    <= 1'b0;
            wheel    <= 1'b0;
          end
        end
        STREAM: begin
          if (bus.rx_err) begin
            pkt_idx <= '0;
          end else if (bus.rx_valid) begin
            if (pkt_idx == 2'd0) begin
              // bit3 is always set in a header byte; anything else is out of sync
              if (bus.rx_data[3]) begin
                b0      <= bus.rx_data;
                pkt_idx <= 2'd1;
              end
            end else if (pkt_idx == 2'd1) begin
`ifdef PS2_HOTPLUG_EN
              if (b0 == 8'hAA && bus.rx_data == 8'h00) begin
                ready   <= 1'b0;
                wheel   <= 1'b0;
                idx     <= 4'd1;
                retry   <= '0;
                pkt_idx <= '0;
                state   <= SEND;
              end else begin
                b1      <= bus.rx_data;
                pkt_idx <= 2'd2;
              end
`else
              b1      <= bus.rx_data;
              pkt_idx <= 2'd2;
`endif
            end else if (pkt_idx == last_idx) begin
              pkt_valid <= 1'b1;
              btn       <= b0[2:0];
              dx        <= {b0[4], b1};
              dy        <= {b0[5], y_lo};
              dz        <= wheel ? bus.rx_data[3:0] : 4'd0;
              ovf       <= {b0[7], b0[6]};
              pkt_idx   <= '0;
            end else begin
              b2      <= bus.rx_data;
              pkt_idx <= 2'd3;
            end
          end else if (pkt_idx != 2'd0 && ack_to) begin
            pkt_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_mouse_host_ctrl.sv
// Scoreboard bench for ps2_mouse_host_ctrl: queued expected tx bytes and packets checked by a monitor.
module tb_ps2_mouse_host_ctrl;
  localparam int ACK_T = 50;
  localparam int BAT_T = 200;
  localparam int RMAX  = 3;
  localparam int BACK  = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready, init_err, wheel, pkt_valid;
  logic [2:0] btn;
  logic [8:0] dx, dy;
  logic [3:0] dz;
  logic [1:0] ovf;

  ps2_mouse_host_ctrl_if bus ();

  ps2_mouse_host_ctrl #(
    .ACK_TIMEOUT(ACK_T), .BAT_TIMEOUT(BAT_T), .RETRY_MAX(RMAX), .ERR_BACKOFF(BACK)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ready(ready), .init_err(init_err), .wheel(wheel), .pkt_valid(pkt_valid),
    .btn(btn), .dx(dx), .dy(dy), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0]  exp_tx[$];
  logic [26:0] exp_pkt[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // monitor: every tx_req and pkt_valid pops its expected entry
  always @(posedge clk) begin
    logic [7:0]  et;
    logic [26:0] ep;
    #1;
    if (bus.tx_req) begin
      if (exp_tx.size() == 0) chk("tx_extra", {24'd0, bus.tx_data}, 32'h1FF);
      else begin et = exp_tx.pop_front(); chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, et}); end
    end
    if (pkt_valid) begin
      if (exp_pkt.size() == 0) chk("pkt_extra", {5'd0, btn, dx, dy, dz, ovf}, 32'hFFFF_FFFF);
      else begin ep = exp_pkt.pop_front(); chk("pkt", {5'd0, btn, dx, dy, dz, ovf}, {5'd0, ep}); end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] script_byte(input int i);
    logic [7:0] tbl [9] = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
    return tbl[i];
  endfunction

  task automatic rx(input logic [7:0] d);
    @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = d;
    @(negedge clk); bus.rx_valid = 1'b0;
  endtask

  // wait for a tx request, act as transceiver, then return nrep reply bytes
  task automatic xfer(input int nrep, input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.tx_req && n < 1000);
    chk("tx_wait", {31'd0, bus.tx_req}, 32'd1);
    if (!bus.tx_req) return;
    @(negedge clk); bus.tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    bus.tx_busy = 1'b0; bus.tx_done = 1'b1;
    @(negedge clk); bus.tx_done = 1'b0;
    if (nrep > 0) rx(r0);
    if (nrep > 1) rx(r1);
    if (nrep > 2) rx(r2);
  endtask

  task automatic run_script(input int start, input logic [7:0] id, input int fe_at);
    for (int i = start; i < 9; i++) begin
      exp_tx.push_back(script_byte(i));
      if (i == fe_at) begin
        exp_tx.push_back(script_byte(i));
        xfer(1, 8'hFE, 8'h00, 8'h00);
      end
      case (i)
        0:       xfer(3, 8'hFA, 8'hAA, 8'h00);
        7:       xfer(2, 8'hFA, id, 8'h00);
        default: xfer(1, 8'hFA, 8'h00, 8'h00);
      endcase
    end
    chk("ready", {31'd0, ready}, 32'd1);
    chk("wheel", {31'd0, wheel}, {31'd0, id == 8'h03});
    chk("init_err", {31'd0, init_err}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.tx_busy = 1'b0; bus.tx_done = 1'b0; bus.tx_err = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_err = 1'b0; bus.rx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_init_err", {31'd0, init_err}, 32'd0);
    chk("rst_wheel", {31'd0, wheel}, 32'd0);
    chk("rst_tx_req", {31'd0, bus.tx_req}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_decode", {5'd0, pkt_valid, btn, dx, dy, dz, ovf}, 32'd0);
    rst = 1'b1;
  endtask

  task automatic pkt(input logic [2:0] b, input logic [8:0] x, input logic [8:0] y,
                     input logic [3:0] z, input logic [1:0] o);
    exp_pkt.push_back({b, x, y, z, o});
  endtask

  initial begin
    rst = 1'b0;
    do_reset();

    // IntelliMouse path
    run_script(0, 8'h03, -1);
    pkt(3'b001, 9'h005, 9'h1FB, 4'h1, 2'b00);
    rx(8'h29); rx(8'h05); rx(8'hFB); rx(8'h01);
    repeat (3) @(negedge clk);

    // plain mouse, with one FE on idx 1
    do_reset();
    run_script(0, 8'h00, 1);
    pkt(3'b000, 9'h1FF, 9'h002, 4'h0, 2'b00);
    rx(8'h18); rx(8'hFF); rx(8'h02);

    // resync: stray byte dropped
    pkt(3'b000, 9'h001, 9'h001, 4'h0, 2'b00);
    rx(8'h02); rx(8'h08); rx(8'h01); rx(8'h01);
    // inter-byte gap drops partial packet
    pkt(3'b000, 9'h003, 9'h004, 4'h0, 2'b00);
    rx(8'h08); rx(8'h01);
    repeat (ACK_T + 30) @(negedge clk);
    rx(8'h08); rx(8'h03); rx(8'h04);
    // rx_err drops partial packet
    pkt(3'b000, 9'h005, 9'h006, 4'h0, 2'b00);
    rx(8'h08);
    @(negedge clk); bus.rx_err = 1'b1;
    @(negedge clk); bus.rx_err = 1'b0;
    rx(8'h08); rx(8'h05); rx(8'h06);
    // rx_valid with rx_err: byte discarded
    pkt(3'b000, 9'h007, 9'h007, 4'h0, 2'b00);
    rx(8'h08);
    @(negedge clk); bus.rx_valid = 1'b1; bus.rx_err = 1'b1; bus.rx_data = 8'h09;
    @(negedge clk); bus.rx_valid = 1'b0; bus.rx_err = 1'b0;
    rx(8'h08); rx(8'h07); rx(8'h07);
    repeat (3) @(negedge clk);

`ifdef PS2_HOTPLUG_EN
    rx(8'hAA); rx(8'h00);
    chk("hp_ready", {31'd0, ready}, 32'd0);
    chk("hp_wheel", {31'd0, wheel}, 32'd0);
    run_script(1, 8'h03, -1);
`else
    pkt(3'b010, 9'h000, 9'h105, 4'h0, 2'b10);
    rx(8'hAA); rx(8'h00); rx(8'h05);
    repeat (3) @(negedge clk);
    chk("aa00_ready", {31'd0, ready}, 32'd1);
`endif

    // no reply to FF: three attempts, then ERROR, then FF again after backoff
    do_reset();
    for (int i = 0; i < RMAX; i++) begin
      exp_tx.push_back(8'hFF);
      xfer(0, 8'h00, 8'h00, 8'h00);
    end
    begin
      int n = 0;
      while (!init_err && n < 200) begin @(negedge clk); n++; end
    end
    chk("err_set", {31'd0, init_err}, 32'd1);
    chk("err_ready", {31'd0, ready}, 32'd0);
    exp_tx.push_back(8'hFF);
    xfer(0, 8'h00, 8'h00, 8'h00);
    chk("err_clear", {31'd0, init_err}, 32'd0);

    // reset while waiting for the ACK, then the whole script again
    do_reset();
    run_script(0, 8'h03, -1);

    repeat (10) @(negedge clk);
    chk("tx_q_empty", exp_tx.size(), 32'd0);
    chk("pkt_q_empty", exp_pkt.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
